rhd_spi_sequencer: RTL and testbench
====================================

Name: rhd_spi_sequencer

Overview:
- Drives the SPI link to one RHD amplifier chip, cycling through the 35 command slots of a sampling frame.
- Slots 0–31 are amplifier channels; slots 32–34 are aux commands.
- Outputs the slot index `channel` to the command selector, takes back the 16-bit `MOSI_cmd`, and serializes it (CPOL=0, CPHA=0, MSB first).
- Captures the 16-bit MISO word of every slot and presents it with a valid strobe to the downstream sample packer.

Parameters:
- CLK_DIV, 2, clk cycles per SCLK half-period; legal range 1–15.
- NUM_SLOTS, 35, command slots per frame; legal range 2–64.
- CS_GAP, 2, clk cycles cs_n is held high between slots; legal range 1–15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; frames are issued while high
- channel  out  6  current slot index to the command selector
- MOSI_cmd  in  16  command word for `channel`; combinational from the selector
- cs_n  out  1  SPI chip select, active low
- sclk  out  1  SPI clock
- mosi  out  1  SPI data to chip
- miso  in  1  SPI data from chip (already synchronized upstream)
- rx_data  out  16  word received in the completed slot
- rx_slot  out  6  slot index in which rx_data was received
- rx_valid  out  1  one-clk strobe; rx_data and rx_slot are valid
- frame_start  out  1  one-clk pulse when slot 0 begins; advances the aux command RAM
- frame_done  out  1  one-clk pulse after the last slot's CS_GAP
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, immediate, including mid-shift):
  - state=IDLE; cs_n=1, sclk=0, mosi=0, channel=0.
  - rx_data=0, rx_slot=0, rx_valid=0, frame_start=0, frame_done=0, busy=0.
  - No partial word is emitted.
- States: IDLE, LOAD, CS_SETUP, SHIFT, CS_HOLD, GAP.
- IDLE:
  - channel=0, cs_n=1, sclk=0.
  - If run=1, go to LOAD and assert frame_start for that clk.
- LOAD (1 clk):
  - Latch MOSI_cmd into tx shift register; `channel` has been stable at least 1 clk, so the selector output is settled.
  - Clear bit counter (0..15) and divider.
  - cs_n stays high; go to CS_SETUP.
- CS_SETUP (1 clk): cs_n=0, sclk=0, mosi=tx[15]; go to SHIFT.
- SHIFT (16 bits, each 2*CLK_DIV clks):
  - Low phase: sclk=0 for CLK_DIV clks, mosi=current bit.
  - On the clk edge that drives sclk 0->1: shift miso into rx register LSB, MSB first.
  - High phase: sclk=1 for CLK_DIV clks.
  - On the edge driving sclk 1->0: mosi advances to the next bit and the bit counter increments.
  - After the 16th high phase, sclk=0; go to CS_HOLD.
- CS_HOLD (1 clk):
  - cs_n=0, sclk=0.
  - Load rx_data, set rx_slot=channel, pulse rx_valid.
- GAP (CS_GAP clks):
  - cs_n=1, mosi=0.
  - On the last GAP clk:
    - If channel < NUM_SLOTS-1: channel increments, go to LOAD.
    - Otherwise: channel=0 and frame_done pulses.
      - If run=1, go to LOAD with frame_start pulsing in the same clk (back-to-back frames, no dead time).
      - Otherwise go to IDLE.
- Slot length = 2 + 32*CLK_DIV + CS_GAP + 1 (LOAD) clks; defaults give 69. Frame = NUM_SLOTS*slot length; defaults give 2415.
- run is sampled only in IDLE and on the frame-end clk. Dropping run mid-frame completes the current frame fully, with all 35 rx_valid pulses.
- channel changes only on the GAP->LOAD transition or on reset; it never changes while cs_n=0.
- rx_valid fires exactly once per slot; frame_start and frame_done are never high in the same clk except at a back-to-back frame boundary.
- No pipeline alignment is done: rx_slot tags the transfer slot. Any chip-side result latency is handled downstream.

Test Plan:
- run=1 for one frame then 0, defaults, selector model returning {2'b00,ch,8'h00} -> 35 cs_n low windows, each exactly 16 sclk rising edges; frame_done at clk 2415 after frame_start; IDLE afterwards, busy=0.
- miso looped to mosi, MOSI_cmd=16'hA5C3 for every slot -> every rx_data=16'hA5C3, rx_slot sequence 0..34, 35 rx_valid pulses.
- CLK_DIV=1, CS_GAP=1 -> sclk period 2 clks, slot length 36 clks; mosi stable across every sclk rising edge.
- run held high for 3 frames -> frame_start at clks 0, 2415, 4830; each coincides with the preceding frame_done; channel wraps 34->0 with no extra idle clk.
- run dropped during slot 10 -> slots 11–34 still issued; frame_done once; no further cs_n activity.
- rst_n asserted during bit 7 of slot 5 -> same clk: cs_n=1, sclk=0, channel=0, no rx_valid. After release with run=1, a new frame starts at slot 0 with frame_start.

Source files
------------

// File: rtl/rhd_spi_sequencer.sv
// SPI master for one RHD amplifier chip: walks the command slots of a sampling
// frame, shifts each 16-bit command out and each 16-bit reply in.
//
// state      | meaning
// IDLE       | waiting for run, cs_n high, channel parked at 0
// LOAD       | latch selector word for current channel
// CS_SETUP   | cs_n low, first bit on mosi
// SHIFT      | 16 sclk periods, miso sampled on rising edges
// CS_HOLD    | cs_n still low, received word published
// GAP        | cs_n high for CS_GAP clks, then next slot or frame end
module rhd_spi_sequencer #(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned NUM_SLOTS = 35,
    parameter int unsigned CS_GAP    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    output logic [5:0]  channel,
    input  logic [15:0] MOSI_cmd,
    output logic        cs_n,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic [15:0] rx_data,
    output logic [5:0]  rx_slot,
    output logic        rx_valid,
    output logic        frame_start,
    output logic        frame_done,
    output logic        busy
);

    localparam logic [3:0] DIV_TC    = 4'(CLK_DIV - 1);
    localparam logic [3:0] GAP_TC    = 4'(CS_GAP - 1);
    localparam logic [5:0] LAST_SLOT = 6'(NUM_SLOTS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CS_SETUP,
        S_SHIFT,
        S_CS_HOLD,
        S_GAP
    } state_t;

    state_t      state;
    logic [15:0] tx;
    logic [15:0] rx;
    logic [3:0]  bit_cnt;
    logic [3:0]  div_cnt;
    logic [3:0]  gap_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            channel     <= '0;
            cs_n        <= 1'b1;
            sclk        <= 1'b0;
            mosi        <= 1'b0;
            tx          <= '0;
            rx          <= '0;
            bit_cnt     <= '0;
            div_cnt     <= '0;
            gap_cnt     <= '0;
            rx_data     <= '0;
            rx_slot     <= '0;
            rx_valid    <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    channel <= '0;
                    cs_n    <= 1'b1;
                    sclk    <= 1'b0;
                    mosi    <= 1'b0;
                    if (run) begin
                        busy        <= 1'b1;
                        frame_start <= 1'b1;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    tx      <= MOSI_cmd;
                    rx      <= '0;
                    bit_cnt <= '0;
                    div_cnt <= DIV_TC;
                    cs_n    <= 1'b0;
                    mosi    <= MOSI_cmd[15];
                    state   <= S_CS_SETUP;
                end
                S_CS_SETUP: begin
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (div_cnt != 4'd0) begin
                        div_cnt <= div_cnt - 4'd1;
                    end else begin
                        div_cnt <= DIV_TC;
                        if (!sclk) begin
                            sclk <= 1'b1;
                            rx   <= {rx[14:0], miso};
                        end else begin
                            // falling edge: present next bit; after bit 15 this shifts in a 0
                            sclk    <= 1'b0;
                            tx      <= {tx[14:0], 1'b0};
                            mosi    <= tx[14];
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd15) begin
                                rx_data  <= rx;
                                rx_slot  <= channel;
                                rx_valid <= 1'b1;
                                state    <= S_CS_HOLD;
                            end
                        end
                    end
                end
                S_CS_HOLD: begin
                    cs_n    <= 1'b1;
                    mosi    <= 1'b0;
                    gap_cnt <= GAP_TC;
                    state   <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt != 4'd0) begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end else if (channel < LAST_SLOT) begin
                        channel <= channel + 6'd1;
                        state   <= S_LOAD;
                    end else begin
                        channel    <= '0;
                        frame_done <= 1'b1;
                        if (run) begin
                            frame_start <= 1'b1;
                            state       <= S_LOAD;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rhd_spi_sequencer.sv
// Bench for rhd_spi_sequencer: slot-position reference model checked every clk,
// plus directed frame scenarios and a second instance with CLK_DIV=1, CS_GAP=1.
module tb_rhd_spi_sequencer;

    localparam int D    = 2;
    localparam int G    = 2;
    localparam int N    = 35;
    localparam int SLOT = 3 + 32 * D + G;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [5:0]  channel;
    logic [15:0] MOSI_cmd;
    logic        cs_n, sclk, mosi, miso;
    logic [15:0] rx_data;
    logic [5:0]  rx_slot;
    logic        rx_valid, frame_start, frame_done, busy;

    logic        run2;
    logic [5:0]  channel2;
    logic [15:0] MOSI_cmd2;
    logic        cs_n2, sclk2, mosi2, miso2;
    logic [15:0] rx_data2;
    logic [5:0]  rx_slot2;
    logic        rx_valid2, frame_start2, frame_done2, busy2;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          sel_mode = 0;
    logic        loop = 1'b0;
    logic        miso_rnd = 1'b0;
    logic [15:0] cmd_tab [64];

    assign MOSI_cmd  = (sel_mode == 0) ? {2'b00, channel, 8'h00} :
                       (sel_mode == 1) ? 16'hA5C3 : cmd_tab[channel];
    assign miso      = loop ? mosi : miso_rnd;
    assign MOSI_cmd2 = cmd_tab[channel2];
    assign miso2     = mosi2;

    rhd_spi_sequencer dut (
        .clk(clk), .rst_n(rst_n), .run(run), .channel(channel), .MOSI_cmd(MOSI_cmd),
        .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso), .rx_data(rx_data),
        .rx_slot(rx_slot), .rx_valid(rx_valid), .frame_start(frame_start),
        .frame_done(frame_done), .busy(busy)
    );

    rhd_spi_sequencer #(.CLK_DIV(1), .NUM_SLOTS(4), .CS_GAP(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .run(run2), .channel(channel2), .MOSI_cmd(MOSI_cmd2),
        .cs_n(cs_n2), .sclk(sclk2), .mosi(mosi2), .miso(miso2), .rx_data(rx_data2),
        .rx_slot(rx_slot2), .rx_valid(rx_valid2), .frame_start(frame_start2),
        .frame_done(frame_done2), .busy(busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

    initial begin
        forever begin
            @(posedge clk);
            #1 miso_rnd = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: frame position as (active, slot, clk-in-slot).
    int          m_act = 0, m_s = 0, m_t = 0;
    bit          m_fs = 0, m_fd = 0;
    logic [15:0] m_rxw = '0;
    logic        miso_smp = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act = 0; m_s = 0; m_t = 0; m_fs = 0; m_fd = 0; m_rxw = '0;
        end else begin
            m_fs = 0;
            m_fd = 0;
            if (m_act != 0) begin
                if (m_t >= 2 && m_t <= 1 + 32 * D && (m_t - 2) % (2 * D) == D - 1)
                    m_rxw = {m_rxw[14:0], miso_smp};
                m_t++;
                if (m_t == SLOT) begin
                    m_t = 0;
                    if (m_s < N - 1) m_s++;
                    else begin
                        m_fd = 1;
                        m_s  = 0;
                        if (run) m_fs = 1;
                        else m_act = 0;
                    end
                end
            end else if (run) begin
                m_act = 1; m_s = 0; m_t = 0; m_fs = 1;
            end
        end
    end

    logic [15:0] e_cmd;
    int          e_bit;
    logic        e_cs, e_sclk, e_mosi, e_rv;
    logic        prev_cs = 1'b1, prev_sclk = 1'b0;
    int          rises = 0, nwin = 0, nrv = 0, nboth = 0;
    logic        lit_mode = 1'b0;
    int          exp_slot = 0;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            e_cmd  = (sel_mode == 0) ? {2'b00, 6'(m_s), 8'h00} :
                     (sel_mode == 1) ? 16'hA5C3 : cmd_tab[m_s];
            e_bit  = (m_t < 2) ? 0 : (m_t - 2) / (2 * D);
            e_cs   = !(m_act != 0 && m_t >= 1 && m_t <= 2 + 32 * D);
            e_sclk = (m_act != 0 && m_t >= 2 && m_t <= 1 + 32 * D && ((m_t - 2) / D) % 2 == 1);
            e_mosi = (m_act != 0 && m_t >= 1 && m_t <= 1 + 32 * D) ? e_cmd[15 - e_bit] : 1'b0;
            e_rv   = (m_act != 0 && m_t == 2 + 32 * D);
            chk("cs_n", cs_n, e_cs);
            chk("sclk", sclk, e_sclk);
            chk("mosi", mosi, e_mosi);
            chk("channel", channel, (m_act != 0) ? m_s : 0);
            chk("rx_valid", rx_valid, e_rv);
            chk("frame_start", frame_start, m_fs);
            chk("frame_done", frame_done, m_fd);
            chk("busy", busy, (m_act != 0) ? 1 : 0);
            if (e_rv) begin
                chk("rx_data", rx_data, m_rxw);
                chk("rx_slot", rx_slot, m_s);
            end
            if (prev_cs && !cs_n) begin
                rises = 0;
                nwin++;
            end
            if (!cs_n && sclk && !prev_sclk) rises++;
            if (!prev_cs && cs_n) chk("sclk_rises_per_window", rises, 16);
            if (rx_valid) nrv++;
            if (frame_start && frame_done) nboth++;
            if (lit_mode && rx_valid) begin
                chk("loopback_rx_data", rx_data, 16'hA5C3);
                chk("loopback_rx_slot", rx_slot, exp_slot);
                exp_slot = (exp_slot + 1) % N;
            end
            prev_cs   = cs_n;
            prev_sclk = sclk;
        end else begin
            prev_cs   = 1'b1;
            prev_sclk = 1'b0;
        end
        miso_smp = miso;
    end

    logic        p_cs2 = 1'b1, p_sclk2 = 1'b0, p_mosi2 = 1'b0;
    int          rises2 = 0, last_rise2 = -1, exp_slot2 = 0, nrv2 = 0;
    logic [15:0] w2;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (p_cs2 && !cs_n2) begin
                rises2     = 0;
                last_rise2 = -1;
            end
            if (!cs_n2 && sclk2 && !p_sclk2) begin
                w2 = cmd_tab[exp_slot2];
                if (rises2 < 16) begin
                    chk("dut2_mosi_before_rise", p_mosi2, w2[15 - rises2]);
                    chk("dut2_mosi_at_rise", mosi2, w2[15 - rises2]);
                end
                if (last_rise2 >= 0) chk("dut2_sclk_period", cyc - last_rise2, 2);
                last_rise2 = cyc;
                rises2++;
            end
            if (!p_cs2 && cs_n2) chk("dut2_rises_per_window", rises2, 16);
            if (rx_valid2) begin
                chk("dut2_rx_data", rx_data2, cmd_tab[exp_slot2]);
                chk("dut2_rx_slot", rx_slot2, exp_slot2);
                exp_slot2 = (exp_slot2 + 1) % 4;
                nrv2++;
            end
            p_cs2   = cs_n2;
            p_sclk2 = sclk2;
            p_mosi2 = mosi2;
        end else begin
            p_cs2   = 1'b1;
            p_sclk2 = 1'b0;
        end
    end

    task automatic wait_for(input int which, input int arg, input int bound, input string name);
        bit hit;
        hit = 0;
        for (int i = 0; i < bound && !hit; i++) begin
            @(negedge clk);
            case (which)
                0: hit = frame_start;
                1: hit = frame_done;
                2: hit = (channel == 6'(arg));
                3: hit = !busy;
                4: hit = frame_start2;
                5: hit = frame_done2;
                default: hit = 1;
            endcase
        end
        #1;
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL %s: event not seen within %0d cycles, required it to occur", name, bound);
        end
    endtask

    int c0, base_rv, base_win, base_both;

    initial begin
        rst_n = 1'b0;
        run   = 1'b0;
        run2  = 1'b0;
        for (int i = 0; i < 64; i++) cmd_tab[i] = 16'($urandom);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("reset_cs_n", cs_n, 1);
        chk("reset_sclk", sclk, 0);
        chk("reset_mosi", mosi, 0);
        chk("reset_channel", channel, 0);
        chk("reset_rx_data", rx_data, 0);
        chk("reset_rx_slot", rx_slot, 0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_frame_start", frame_start, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_busy", busy, 0);
        repeat (3) @(negedge clk);

        // single frame, selector {00,ch,00}
        sel_mode = 0;
        run = 1'b1;
        wait_for(0, 0, 10, "single_frame_start");
        c0 = cyc; base_rv = nrv; base_win = nwin;
        repeat (100) @(negedge clk);
        run = 1'b0;
        wait_for(1, 0, 2500, "single_frame_done");
        chk("single_frame_length", cyc - c0, 2415);
        chk("single_rx_valid_count", nrv - base_rv, 35);
        chk("single_cs_windows", nwin - base_win, 35);
        repeat (10) @(negedge clk);
        #1 chk("single_idle_busy", busy, 0);

        // loopback with constant command
        sel_mode = 1; loop = 1'b1; lit_mode = 1'b1; exp_slot = 0;
        base_rv = nrv;
        run = 1'b1;
        wait_for(0, 0, 10, "loop_frame_start");
        run = 1'b0;
        wait_for(1, 0, 2500, "loop_frame_done");
        chk("loop_rx_valid_count", nrv - base_rv, 35);
        lit_mode = 1'b0; loop = 1'b0;
        repeat (5) @(negedge clk);

        // three back-to-back frames, random commands
        for (int i = 0; i < 64; i++) cmd_tab[i] = 16'($urandom);
        sel_mode = 2;
        base_both = nboth;
        run = 1'b1;
        wait_for(0, 0, 10, "b2b_start0");
        c0 = cyc;
        wait_for(0, 0, 2500, "b2b_start1");
        chk("b2b_start1_offset", cyc - c0, 2415);
        wait_for(0, 0, 2500, "b2b_start2");
        chk("b2b_start2_offset", cyc - c0, 4830);
        run = 1'b0;
        wait_for(1, 0, 2500, "b2b_last_done");
        chk("b2b_last_done_offset", cyc - c0, 7245);
        chk("b2b_start_done_coincide", nboth - base_both, 2);
        repeat (5) @(negedge clk);

        // random run toggling
        for (int k = 0; k < 4; k++) begin
            run = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 3000)) @(negedge clk);
        end
        run = 1'b0;
        wait_for(3, 0, 2500, "random_run_idle");
        repeat (5) @(negedge clk);

        // drop run in slot 10
        run = 1'b1;
        wait_for(0, 0, 10, "drop_frame_start");
        base_rv = nrv;
        wait_for(2, 10, 800, "drop_reach_slot10");
        repeat (20) @(negedge clk);
        run = 1'b0;
        wait_for(1, 0, 2500, "drop_frame_done");
        chk("drop_rx_valid_count", nrv - base_rv, 35);
        base_win = nwin;
        repeat (300) @(negedge clk);
        chk("drop_no_more_windows", nwin - base_win, 0);
        chk("drop_idle_busy", busy, 0);

        // reset during bit 7 of slot 5
        run = 1'b1;
        wait_for(0, 0, 10, "rst_frame_start");
        wait_for(2, 5, 400, "rst_reach_slot5");
        repeat (31) @(posedge clk);
        #1 chk("rst_pre_cs_n", cs_n, 0);
        base_rv = nrv;
        rst_n = 1'b0;
        #1;
        chk("rst_cs_n", cs_n, 1);
        chk("rst_sclk", sclk, 0);
        chk("rst_channel", channel, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mosi", mosi, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_for(0, 0, 5, "rst_restart_frame_start");
        chk("rst_restart_channel", channel, 0);
        chk("rst_no_partial_word", nrv - base_rv, 0);
        run = 1'b0;
        wait_for(1, 0, 2500, "rst_restart_done");
        repeat (5) @(negedge clk);

        // fast instance: CLK_DIV=1, CS_GAP=1, 4 slots
        for (int i = 0; i < 64; i++) cmd_tab[i] = 16'($urandom);
        exp_slot2 = 0;
        base_rv = nrv2;
        run2 = 1'b1;
        wait_for(4, 0, 5, "dut2_frame_start");
        c0 = cyc;
        run2 = 1'b0;
        wait_for(5, 0, 200, "dut2_frame_done");
        chk("dut2_frame_length", cyc - c0, 144);
        chk("dut2_rx_valid_count", nrv2 - base_rv, 4);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
